// File: rtl/flash_adc_sample_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : flash_adc_pkg
// Description : Shared types and constants for the flash ADC sample controller
//               and its thermometer decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package flash_adc_pkg;

    localparam int COMP_W    = 4;
    localparam int B_W       = 2;
    localparam int NUM_LEGAL = 5;

    // Every code a healthy comparator ladder can produce, lowest input first.
    localparam logic [COMP_W-1:0] LEGAL_CODES [NUM_LEGAL] = '{
        4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    function automatic logic is_therm(input logic [COMP_W-1:0] code);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_LEGAL; i++) begin
            if (code == LEGAL_CODES[i]) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage
`default_nettype wire

// File: rtl/flash_adc_sample_ctrl_therm_decode.sv
`default_nettype none
// ============================================================================
// Module      : therm_decode
// Description : Combinational thermometer-to-binary decode with bubble and
//               overrange detection for one comparator sample.
// Revision    : 1.0 - initial release
// ============================================================================
module therm_decode
    import flash_adc_pkg::*;
(
    input  logic [COMP_W-1:0] i_comp,
    output logic [B_W-1:0]    o_d,
    output logic              o_bubble,
    output logic              o_ovr
);

    logic [2:0] w_ones;

    // Counting ones instead of locating the edge keeps a single bubble from
    // producing a wildly wrong level.
    assign w_ones   = 3'($countones(i_comp));
    assign o_d      = (w_ones == 3'd0) ? 2'd3 : 2'(3'd4 - w_ones);
    assign o_bubble = ~is_therm(i_comp);
    assign o_ovr    = (i_comp == '0);

endmodule
`default_nettype wire

// File: rtl/flash_adc_sample_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : flash_adc_sample_ctrl
// Description : Settle/strobe/average sequencer for a 4-comparator flash ADC
//               with a valid/ready result port and sticky error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module flash_adc_sample_ctrl
    import flash_adc_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int LOG2_SAMPLES  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cont_mode,
    input  logic [COMP_W-1:0] COMP,
    output logic              sample_en,
    output logic              busy,
    output logic [B_W-1:0]    B,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              bubble_err,
    output logic              overrange
);

    localparam int NUM_SAMPLES = 1 << LOG2_SAMPLES;
    localparam int ACC_W       = B_W + LOG2_SAMPLES;
    localparam int CNT_MAX     = (SETTLE_CYCLES > NUM_SAMPLES - 1) ?
                                 SETTLE_CYCLES : NUM_SAMPLES - 1;
    localparam int CNT_W       = $clog2(CNT_MAX + 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [ACC_W-1:0]   r_acc;
    logic               r_bub;
    logic               r_ovr;
    logic [B_W-1:0]     r_b;
    logic               r_bubble_err;
    logic               r_overrange;
    logic               r_valid;
    logic               r_sample_en;
    logic               r_busy;

    logic [B_W-1:0]     w_d;
    logic               w_bubble;
    logic               w_ovr;
    logic [ACC_W-1:0]   w_acc_next;
    logic               w_accept;

    therm_decode u_decode (
        .i_comp   (COMP),
        .o_d      (w_d),
        .o_bubble (w_bubble),
        .o_ovr    (w_ovr)
    );

    assign w_acc_next = r_acc + ACC_W'(w_d);
    assign w_accept   = result_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_acc        <= '0;
            r_bub        <= 1'b0;
            r_ovr        <= 1'b0;
            r_b          <= '0;
            r_bubble_err <= 1'b0;
            r_overrange  <= 1'b0;
            r_valid      <= 1'b0;
            r_sample_en  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_SETTLE;
                        r_cnt   <= '0;
                        r_acc   <= '0;
                        r_bub   <= 1'b0;
                        r_ovr   <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt == CNT_W'(SETTLE_CYCLES)) begin
                        r_state     <= ST_SAMPLE;
                        r_cnt       <= '0;
                        r_sample_en <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_SAMPLE: begin
                    r_acc <= w_acc_next;
                    r_bub <= r_bub | w_bubble;
                    r_ovr <= r_ovr | w_ovr;
                    if (r_cnt == CNT_W'(NUM_SAMPLES - 1)) begin
                        // Publish from the next-state values so the last
                        // sample lands in this result.
                        r_state      <= ST_DONE;
                        r_cnt        <= '0;
                        r_sample_en  <= 1'b0;
                        r_valid      <= 1'b1;
                        r_b          <= w_acc_next[ACC_W-1:LOG2_SAMPLES];
                        r_bubble_err <= r_bub | w_bubble;
                        r_overrange  <= r_ovr | w_ovr;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (w_accept) begin
                        r_valid <= 1'b0;
                        if (cont_mode) begin
                            r_state <= ST_SETTLE;
                            r_cnt   <= '0;
                            r_acc   <= '0;
                            r_bub   <= 1'b0;
                            r_ovr   <= 1'b0;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_valid     <= 1'b0;
                    r_sample_en <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign sample_en    = r_sample_en;
    assign busy         = r_busy;
    assign B            = r_b;
    assign result_valid = r_valid;
    assign bubble_err   = r_bubble_err;
    assign overrange    = r_overrange;

endmodule
`default_nettype wire

// File: tb/tb_flash_adc_sample_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_flash_adc_sample_ctrl
// Description : Self-checking bench for flash_adc_sample_ctrl with a
//               conversion-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flash_adc_sample_ctrl;

    localparam int S  = 2;
    localparam int L  = 2;
    localparam int NS = 1 << L;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       cont_mode;
    logic       result_ready;
    logic [3:0] COMP;
    logic       sample_en;
    logic       busy;
    logic [1:0] B;
    logic       result_valid;
    logic       bubble_err;
    logic       overrange;

    int total = 0;
    int bad   = 0;

    logic [3:0] plan [NS];
    logic [3:0] legal [5] = '{4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};

    always #5 clk = ~clk;

    flash_adc_sample_ctrl #(
        .SETTLE_CYCLES (S),
        .LOG2_SAMPLES  (L)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cont_mode    (cont_mode),
        .COMP         (COMP),
        .sample_en    (sample_en),
        .busy         (busy),
        .B            (B),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .bubble_err   (bubble_err),
        .overrange    (overrange)
    );

    function automatic logic [7:0] obs();
        return {1'b0, sample_en, busy, result_valid, B, bubble_err, overrange};
    endfunction

    function automatic logic [7:0] ctl();
        return {5'b0, sample_en, busy, result_valid};
    endfunction

    function automatic logic [7:0] mk(input bit se, input bit bz, input bit v,
                                      input logic [1:0] b, input bit bu, input bit ov);
        return {1'b0, se, bz, v, b, bu, ov};
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b exp=%b (en,busy,vld,B,bub,ovr) t=%0t",
                     tag, got[6:0], exp[6:0], $time);
        end
    endtask

    // Conversion-level reference: average of saturated level estimates.
    function automatic void model(output logic [1:0] b, output bit bu, output bit ov);
        int sum;
        int d;
        sum = 0;
        bu  = 1'b0;
        ov  = 1'b0;
        for (int i = 0; i < NS; i++) begin
            d = 4 - $countones(plan[i]);
            if (d > 3) d = 3;
            sum += d;
            if (!(plan[i] inside {4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000})) bu = 1'b1;
            if (plan[i] == 4'b0000) ov = 1'b1;
        end
        b = 2'(sum >> L);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic kick();
        check("idle", ctl(), 8'b000);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Called just after the edge that entered SETTLE.
    task automatic run_body(input int stall, input bit cont, input bit poke);
        logic [1:0] eb;
        bit         ebu;
        bit         eov;
        model(eb, ebu, eov);
        check("settle0", ctl(), 8'b010);
        for (int t = 1; t <= S + NS + 1; t++) begin
            COMP         = (t >= S + 2) ? plan[t-S-2] : 4'($urandom);
            start        = poke ? 1'($urandom) : 1'b0;
            result_ready = 1'($urandom);
            cont_mode    = 1'($urandom);
            step();
            if (t == S + NS + 1)
                check("result", obs(), mk(1'b0, 1'b1, 1'b1, eb, ebu, eov));
            else
                check("seq", ctl(), {5'b0, (t >= S + 1), 1'b1, 1'b0});
        end
        for (int k = 0; k < stall; k++) begin
            result_ready = 1'b0;
            start        = poke ? 1'($urandom) : 1'b0;
            COMP         = 4'($urandom);
            cont_mode    = 1'($urandom);
            step();
            check("hold", obs(), mk(1'b0, 1'b1, 1'b1, eb, ebu, eov));
        end
        result_ready = 1'b1;
        cont_mode    = cont;
        start        = poke ? 1'($urandom) : 1'b0;
        step();
        check("accept", ctl(), {5'b0, 1'b0, cont, 1'b0});
        check("b_keep", {6'b0, B}, {6'b0, eb});
        result_ready = 1'b0;
        start        = 1'b0;
        cont_mode    = 1'b0;
    endtask

    initial begin
        bit chained;
        rst          = 1'b1;
        start        = 1'b1;
        cont_mode    = 1'b0;
        result_ready = 1'b0;
        COMP         = 4'b1100;
        #1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset", obs(), 8'b0);
        end
        rst   = 1'b0;
        start = 1'b0;
        step();
        check("post_reset", obs(), 8'b0);

        // Single conversion, constant mid-scale input.
        foreach (plan[i]) plan[i] = 4'b1100;
        kick();
        run_body(0, 1'b0, 1'b0);

        // Averaging across the four legal codes.
        plan = '{4'b1111, 4'b1110, 4'b1100, 4'b1000};
        kick();
        run_body(0, 1'b0, 1'b0);

        // Bubble plus overrange, then a clean conversion clears the flags.
        plan = '{4'b1010, 4'b1100, 4'b0000, 4'b0000};
        kick();
        run_body(1, 1'b0, 1'b0);
        plan = '{4'b1110, 4'b1110, 4'b1100, 4'b1110};
        kick();
        run_body(0, 1'b0, 1'b0);

        // Backpressure in continuous mode with ignored start pulses.
        foreach (plan[i]) plan[i] = 4'b1100;
        kick();
        run_body(5, 1'b1, 1'b1);
        plan = '{4'b1000, 4'b1000, 4'b1000, 4'b1100};
        run_body(0, 1'b0, 1'b1);

        // Reset during the second SAMPLE cycle.
        kick();
        for (int t = 1; t <= S + 2; t++) begin
            COMP = 4'b1100;
            step();
        end
        check("mid_sample", ctl(), 8'b110);
        rst = 1'b1;
        step();
        check("mid_reset", obs(), 8'b0);
        rst          = 1'b0;
        result_ready = 1'b1;
        for (int i = 0; i < S + NS + 2; i++) begin
            step();
            check("no_valid", obs(), 8'b0);
        end
        result_ready = 1'b0;
        foreach (plan[i]) plan[i] = 4'b1110;
        kick();
        run_body(0, 1'b0, 1'b0);

        // Randomized conversions, optionally chained in continuous mode.
        chained = 1'b0;
        for (int n = 0; n < 12; n++) begin
            bit cont;
            if (!chained) kick();
            foreach (plan[i])
                plan[i] = ($urandom_range(0, 2) == 0) ? 4'($urandom) : legal[$urandom_range(0, 4)];
            cont = (n < 11) ? 1'($urandom) : 1'b0;
            run_body(int'($urandom_range(0, 3)), cont, 1'b1);
            chained = cont;
        end
        step();
        check("final_idle", ctl(), 8'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/flash_adc_sample_ctrl.md
Name: flash_adc_sample_ctrl

Overview:
Sequencing controller for the 4-comparator flash ADC front end and its thermometer-to-binary decode.
- On a start request (or continuously), it waits for the comparator ladder to settle, then strobes and captures NUM_SAMPLES thermometer codes.
- Each code is decoded to 2 bits and the samples are averaged.
- The averaged result is presented on a valid/ready handshake, with bubble-error and overrange flags, to the downstream sample consumer.

Parameters:
SETTLE_CYCLES, 2, cycles waited after start before the first capture (>=1)
LOG2_SAMPLES, 2, log2 of samples averaged per conversion (0..4); NUM_SAMPLES = 2**LOG2_SAMPLES

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle request for a conversion; ignored unless IDLE
cont_mode  input  1  1 = start next conversion automatically after result accepted
COMP  input  4  thermometer code from comparators (1111 = lowest, 0000 = overrange)
sample_en  output  1  comparator strobe; high exactly during SAMPLE cycles
busy  output  1  high in any state other than IDLE
B  output  2  averaged conversion result
result_valid  output  1  result handshake valid
result_ready  input  1  consumer accepts when result_valid & result_ready
bubble_err  output  1  any sample in this conversion was a non-thermometer code
overrange  output  1  any sample in this conversion was 0000

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values: all outputs 0, state IDLE, counters and accumulator cleared. Reset overrides everything, including mid-conversion; no result_valid follows a reset.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
  - IDLE: on start=1, go to SETTLE and clear the accumulator and flags.
  - SETTLE: count SETTLE_CYCLES cycles, then go to SAMPLE.
  - SAMPLE: sample_en=1. COMP is captured at each rising edge while in SAMPLE, for exactly NUM_SAMPLES cycles, then go to DONE.
  - DONE: result_valid=1. B, bubble_err and overrange are stable and held until acceptance.
  - On acceptance in DONE: go to SETTLE if cont_mode=1 (same clear as start), else go to IDLE.
- Latency: start seen at edge N gives result_valid high from edge N+SETTLE_CYCLES+NUM_SAMPLES+1.
- Decode per sample: d = 4 - popcount(COMP), saturated to 3. This gives 1111->0, 1110->1, 1100->2, 1000->3, 0000->3. Ones-count is bubble tolerant.
- bubble_err sets if COMP is not one of {1111, 1110, 1100, 1000, 0000}. overrange sets if COMP == 0000. Both flags are sticky within a conversion.
- Accumulator width is 2+LOG2_SAMPLES; it cannot overflow.
- B = accumulator >> LOG2_SAMPLES (truncating). With LOG2_SAMPLES=0, B is the single decoded sample.
- B and the flags update only on the transition into DONE.
- start asserted while busy is ignored. start is not queued.
- cont_mode is sampled at the acceptance edge. Deasserting it mid-conversion lets the current conversion finish, then the block returns to IDLE.
- Backpressure: result_ready low in DONE holds the state indefinitely; sample_en stays 0.
- result_ready outside DONE has no effect.

Decomposition:
- Package flash_adc_pkg holds:
  - state enum typedef (IDLE/SETTLE/SAMPLE/DONE)
  - constants COMP_W=4, B_W=2
  - the list of legal thermometer codes
- One natural sub-module, therm_decode: combinational. COMP in; d[1:0], bubble and ovr out. It is shared with the standalone decoder and is unit-testable on its own.
- The controller holds the FSM, the settle/sample counter and the accumulator.

Test Plan:
- Reset: rst high 3 cycles with start=1 and COMP=1100 -> all outputs 0 and state IDLE throughout; no result_valid.
- Single conversion, defaults: start pulse, COMP=1100 constant, result_ready=1. Required response:
  - sample_en high 4 cycles
  - result_valid high one cycle at start+7
  - B=2, bubble_err=0, overrange=0
- Averaging: COMP = 1111, 1110, 1100, 1000 on the 4 SAMPLE cycles -> sum 6, B=1, flags 0.
- Bubble/overrange: samples 1010, 1100, 0000, 0000 -> d = 2, 2, 3, 3, sum 10, B=2, bubble_err=1, overrange=1. The next clean conversion clears both flags.
- Backpressure + continuous mode: cont_mode=1, result_ready=0 for 5 cycles in DONE. Required response:
  - B, flags and result_valid held, sample_en=0
  - start pulses during busy are ignored
  - after ready, SETTLE re-entered next cycle and a second result follows 7 cycles after acceptance
- Reset mid-SAMPLE: rst at the 2nd SAMPLE cycle -> next cycle IDLE, sample_en=0, busy=0, no result_valid. A fresh start then produces a correct result (COMP=1110 -> B=1).
